// File: rtl/cnn_fix_pkg.sv
// rtl/cnn_fix_pkg.sv - shared fixed-point widths, limits and FSM state type
package cnn_fix_pkg;

    localparam int IN_W  = 21;
    localparam int OUT_W = 14;
    localparam int ACC_W = 28;
    localparam int SHIFT = 6;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC = 2'd0,
        REQ = 2'd1,
        OUT = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_round_sat.sv
// rtl/cnn_round_sat.sv - combinational round-half-up, shift and saturate from ACC_W to OUT_W
module cnn_round_sat
    import cnn_fix_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic                    i_ovf,
    input  logic                    i_sign,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_sat
);

    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'(1) <<< (SHIFT-1);

    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_shr;
    logic                  w_hi;
    logic                  w_lo;

    // One guard bit keeps the rounding add from wrapping near ACC_MAX
    assign w_rnd = (ACC_W+1)'(i_acc) + RND;
    assign w_shr = w_rnd >>> SHIFT;

    assign w_hi = !w_shr[ACC_W] && (|w_shr[ACC_W-1:OUT_W-1]);
    assign w_lo =  w_shr[ACC_W] && !(&w_shr[ACC_W-1:OUT_W-1]);

    always_comb begin
        o_data = w_shr[OUT_W-1:0];
        o_sat  = 1'b0;
        if (i_ovf) begin
            o_data = i_sign ? OUT_MIN : OUT_MAX;
            o_sat  = 1'b1;
        end else if (w_hi) begin
            o_data = OUT_MAX;
            o_sat  = 1'b1;
        end else if (w_lo) begin
            o_data = OUT_MIN;
            o_sat  = 1'b1;
        end
    end

endmodule

// File: rtl/cnn_acc_requant_21s_14s.sv
// rtl/cnn_acc_requant_21s_14s.sv - dot-product accumulator with bias, requantization and optional ReLU
module cnn_acc_requant_21s_14s
    import cnn_fix_pkg::*;
(
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [OUT_W-1:0] bias,
    input  logic                    relu_en,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_sat
);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_first;
    logic                    r_ovf;
    logic                    r_relu;
    logic signed [OUT_W-1:0] r_out_data;
    logic                    r_out_sat;
    logic                    r_out_valid;

    logic                    w_accept;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W:0]   w_sum;
    logic                    w_add_ovf;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic signed [OUT_W-1:0] w_rs_data;
    logic                    w_rs_sat;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= ACC;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_accept && in_last) w_state_nxt = REQ;
            REQ:     w_state_nxt = OUT;
            OUT:     if (out_ready) w_state_nxt = ACC;
            default: w_state_nxt = ACC;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ACC);
    end

    assign w_accept = in_valid && in_ready;

    // The first beat of a packet starts from the bias aligned to the product scale
    assign w_base    = r_first ? (ACC_W'(bias) <<< SHIFT) : r_acc;
    assign w_sum     = (ACC_W+1)'(w_base) + (ACC_W+1)'(in_data);
    assign w_add_ovf = (w_sum[ACC_W] != w_sum[ACC_W-1]);
    assign w_acc_nxt = w_add_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

    cnn_round_sat u_round_sat (
        .i_acc  (r_acc),
        .i_ovf  (r_ovf),
        .i_sign (r_acc[ACC_W-1]),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_first     <= 1'b1;
            r_ovf       <= 1'b0;
            r_relu      <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_acc   <= w_acc_nxt;
                        r_ovf   <= r_ovf | w_add_ovf;
                        r_first <= 1'b0;
                        if (r_first) r_relu <= relu_en;
                    end
                end
                REQ: begin
                    // ReLU zeroes the value but keeps the saturation flag
                    r_out_data  <= (r_relu && w_rs_data[OUT_W-1]) ? '0 : w_rs_data;
                    r_out_sat   <= w_rs_sat;
                    r_out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_first     <= 1'b1;
                        r_ovf       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_cnn_acc_requant_21s_14s.sv
// tb/tb_cnn_acc_requant_21s_14s.sv - directed scoreboard bench for the accumulate/requantize block
module tb_cnn_acc_requant_21s_14s;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n;
    logic signed [20:0] in_data;
    logic               in_last;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] bias;
    logic               relu_en;
    logic signed [13:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sat;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    exp_t   sb_q[$];
    int     n_vec  = 0;
    int     n_fail = 0;

    longint m_acc;
    bit     m_first;
    bit     m_ovf;
    bit     m_relu;

    localparam longint ACC_MAX_M = 134217727;
    localparam longint ACC_MIN_M = -134217728;

    always #5 ap_clk = ~ap_clk;

    cnn_acc_requant_21s_14s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bias      (bias),
        .relu_en   (relu_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_first = 1'b1;
        m_ovf   = 1'b0;
        m_relu  = 1'b0;
    endtask

    task automatic model_result();
        exp_t   e;
        longint r;
        if (m_ovf) begin
            e.d = (m_acc < 0) ? -8192 : 8191;
            e.s = 1'b1;
        end else begin
            r   = (m_acc + 32) >>> 6;
            e.s = 1'b0;
            if (r > 8191)  begin r = 8191;  e.s = 1'b1; end
            if (r < -8192) begin r = -8192; e.s = 1'b1; end
            e.d = r;
        end
        if (m_relu && e.d < 0) e.d = 0;
        sb_q.push_back(e);
        model_reset();
    endtask

    // Called and returns at a falling edge
    task automatic send_beat(input longint d, input bit last, input longint b, input bit relu);
        int     n = 0;
        longint base;
        while (!in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'sd1);
        in_valid = 1'b1;
        in_data  = 21'(d);
        in_last  = last;
        bias     = 14'(b);
        relu_en  = relu;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        base = m_first ? (b <<< 6) : m_acc;
        if (m_first) m_relu = relu;
        m_first = 1'b0;
        m_acc = base + d;
        if (m_acc > ACC_MAX_M) begin m_acc = ACC_MAX_M; m_ovf = 1'b1; end
        if (m_acc < ACC_MIN_M) begin m_acc = ACC_MIN_M; m_ovf = 1'b1; end
        if (last) model_result();
    endtask

    task automatic get_output(input string tag, input int hold);
        int               n = 0;
        exp_t             e;
        logic signed [13:0] d0;
        logic             s0;
        while (!out_valid && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'sd1);
        d0 = out_data;
        s0 = out_sat;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = 21'sd12345;
            in_last  = 1'b1;
            bias     = 14'sd100;
            @(negedge ap_clk);
            check({tag, "_hold_data"}, 64'(out_data), 64'(d0));
            check({tag, "_hold_sat"}, 64'(out_sat), 64'(s0));
            check({tag, "_hold_inrdy"}, 64'(in_ready), 64'sd0);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'sd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'sd1, 64'sd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_data"}, 64'(out_data), 64'(e.d));
            check({tag, "_sat"}, 64'(out_sat), 64'(e.s));
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, 64'(out_valid), 64'sd0);
    endtask

    initial begin
        ap_rst_n  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        bias      = '0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge ap_clk);
        check("rst_in_ready", 64'(in_ready), 64'sd1);
        check("rst_out_valid", 64'(out_valid), 64'sd0);
        check("rst_out_data", 64'(out_data), 64'sd0);
        check("rst_out_sat", 64'(out_sat), 64'sd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // basic sum and latency
        send_beat(100, 0, 0, 0);
        send_beat(200, 0, 0, 0);
        send_beat(-36, 1, 0, 0);
        check("t1_lat_req", 64'(out_valid), 64'sd0);
        check("t1_inrdy_req", 64'(in_ready), 64'sd0);
        @(negedge ap_clk);
        check("t1_lat_out", 64'(out_valid), 64'sd1);
        check("t1_expect4", 64'(sb_q[0].d), 64'sd4);
        get_output("t1", 0);

        // bias and round half up
        send_beat(100, 0, 1, 0);
        send_beat(200, 0, 7, 0);
        send_beat(-36, 1, 7, 0);
        get_output("t2_bias", 0);
        send_beat(96, 1, 0, 0);
        get_output("t2_pos_half", 0);
        send_beat(-96, 1, 0, 0);
        get_output("t2_neg_half", 0);

        // output saturation
        send_beat(1048575, 1, 0, 0);
        get_output("t3_max", 0);
        send_beat(-1048576, 1, 0, 0);
        get_output("t3_min", 0);

        // ReLU, including mid-packet toggles
        send_beat(-640, 1, 0, 1);
        get_output("t4_relu", 0);
        send_beat(-640, 0, 0, 0);
        send_beat(-64, 1, 0, 1);
        get_output("t4_tog_off", 0);
        send_beat(-640, 0, 0, 1);
        send_beat(-64, 1, 0, 0);
        get_output("t4_tog_on", 0);

        // backpressure with ignored beats, then a packet with a new bias
        send_beat(300, 1, 3, 0);
        get_output("t5_stall", 5);
        send_beat(64, 1, 2, 0);
        get_output("t5_next", 0);

        // reset mid-packet discards the partial sum
        send_beat(1000, 0, 5, 0);
        ap_rst_n = 1'b0;
        model_reset();
        @(negedge ap_clk);
        check("t6_rst_in_ready", 64'(in_ready), 64'sd1);
        check("t6_rst_valid", 64'(out_valid), 64'sd0);
        check("t6_rst_data", 64'(out_data), 64'sd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        send_beat(64, 1, 0, 0);
        get_output("t6_after_rst", 0);

        // accumulator overflow
        for (int i = 0; i < 300; i++) send_beat(1048575, (i == 299), 0, 0);
        get_output("t7_ovf", 0);
        for (int i = 0; i < 300; i++) send_beat(-1048576, (i == 299), 0, 1);
        get_output("t7_ovf_neg_relu", 0);

        check("sb_drained", 64'(sb_q.size()), 64'sd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
